// File: rtl/fib_pkg.sv
// Package shared by the BCD sequence generator and its BCD output converter.
// It holds the FSM state encoding, the mode codes and the seeds of the two
// sequences. It also holds the constant functions clog2() and pow10(), which
// size the datapath from a digit count.
package fib_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CONV_IN  = 3'd1,
    S_OP       = 3'd2,
    S_CONV_OUT = 3'd3,
    S_DONE     = 3'd4
  } state_e;

  localparam logic MODE_FIB   = 1'b0;
  localparam logic MODE_LUCAS = 1'b1;

  // Seeds (t0, t1) of each sequence: F(0)=0, F(1)=1; L(0)=2, L(1)=1.
  localparam int FIB_SEED0 = 0;
  localparam int FIB_SEED1 = 1;
  localparam int LUC_SEED0 = 2;
  localparam int LUC_SEED1 = 1;

  // 10^digits. This is the exclusive upper bound of a digits-wide BCD value.
  function automatic longint unsigned pow10(input int digits);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < digits; i++) r = r * 10;
    return r;
  endfunction

  // Smallest b with 2^b >= v.
  function automatic int clog2(input longint unsigned v);
    int b;
    b = 0;
    while ((64'd1 << b) < v) b++;
    return b;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3 / double dabble).
// It converts one binary bit per cycle, MSB first, for W_B cycles in total.
// The first shift happens on the edge that accepts i_start. o_done_tick is
// high for one cycle right after the last shift, and o_bcd holds the result
// from that cycle on. i_bin must stay below 10^OUT_DIGITS.
//   i_clk, i_reset  clock, asynchronous active-high reset
//   i_start, i_bin  start request and the binary value (sampled when ready)
//   o_ready         idle and able to accept i_start
//   o_done_tick     one-cycle pulse when the conversion completes
//   o_bcd           packed BCD result, MS digit in the top nibble
module bin_to_bcd_seq
  import fib_pkg::*;
#(
  parameter int W_B        = 14,
  parameter int OUT_DIGITS = 4
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic [W_B-1:0]          i_bin,
  output logic                    o_ready,
  output logic                    o_done_tick,
  output logic [4*OUT_DIGITS-1:0] o_bcd
);

  localparam int W_C = clog2(64'(W_B)) + 1;

  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [W_C-1:0]          cnt_q, cnt_d;
  logic [W_B-1:0]          bin_q, bin_d;
  logic [4*OUT_DIGITS-1:0] bcd_q, bcd_d;

  // One double-dabble step. Any digit >= 5 gets +3, then the whole BCD
  // vector shifts left one place and takes in the next binary bit.
  function automatic logic [4*OUT_DIGITS-1:0] dabble(
    input logic [4*OUT_DIGITS-1:0] bcd,
    input logic                    bit_in
  );
    logic [4*OUT_DIGITS-1:0] adj;
    adj = bcd;
    for (int i = 0; i < OUT_DIGITS; i++)
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    return {adj[4*OUT_DIGITS-2:0], bit_in};
  endfunction

  always_comb begin
    busy_d = busy_q;
    done_d = 1'b0;
    cnt_d  = cnt_q;
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    if (!busy_q && i_start) begin
      bcd_d  = dabble('0, i_bin[W_B-1]);
      bin_d  = i_bin << 1;
      cnt_d  = W_C'(W_B - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      bcd_d = dabble(bcd_q, bin_q[W_B-1]);
      bin_d = bin_q << 1;
      cnt_d = cnt_q - W_C'(1);
      if (cnt_q == W_C'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      bin_q  <= '0;
      bcd_q  <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
    end
  end

  assign o_ready     = ~busy_q;
  assign o_done_tick = done_q;
  assign o_bcd       = bcd_q;

endmodule

// File: rtl/fib_seq_bcd.sv
// BCD-in/BCD-out Fibonacci / Lucas generator.
// It converts n from IN_DIGITS BCD digits, iterates the chosen sequence one
// term per cycle and converts the result back to OUT_DIGITS BCD digits.
// A result that does not fit saturates to all-9s and sets o_overflow. An
// input nibble above 9 forces all-9s and sets o_invalid.
//   i_clk, i_reset  clock, asynchronous active-high reset
//   i_start         start request, sampled only while idle
//   i_mode          0 = Fibonacci, 1 = Lucas (latched on start)
//   i_bcd_n         n as packed BCD, MS digit in the top nibble (latched)
//   o_ready         high only in IDLE
//   o_done_tick     one-cycle pulse; result outputs valid from this cycle
//   o_bcd           packed BCD result, held until the next done
//   o_overflow      result saturated (held with o_bcd)
//   o_invalid       bad input digit, result forced to all-9s (held)
module fib_seq_bcd
  import fib_pkg::*;
#(
  parameter int IN_DIGITS  = 2,
  parameter int OUT_DIGITS = 4
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic                    i_mode,
  input  logic [4*IN_DIGITS-1:0]  i_bcd_n,
  output logic                    o_ready,
  output logic                    o_done_tick,
  output logic [4*OUT_DIGITS-1:0] o_bcd,
  output logic                    o_overflow,
  output logic                    o_invalid
);

  localparam int W_N  = clog2(pow10(IN_DIGITS));
  localparam int W_B  = clog2(pow10(OUT_DIGITS));
  localparam int W_IC = clog2(64'(IN_DIGITS)) + 1;
  localparam logic [W_B-1:0] MAX_RES = W_B'(pow10(OUT_DIGITS) - 1);

  state_e                  state_q, state_d;
  logic                    mode_q, mode_d;
  logic [4*IN_DIGITS-1:0]  nib_q, nib_d;
  logic [W_IC-1:0]         in_cnt_q, in_cnt_d;
  logic [W_N-1:0]          n_q, n_d;
  logic [W_B-1:0]          t0_q, t0_d, t1_q, t1_d;
  logic                    invalid_q, invalid_d;
  logic                    overflow_q, overflow_d;
  logic                    o_ready_q, o_ready_d;
  logic                    o_done_tick_q, o_done_tick_d;
  logic [4*OUT_DIGITS-1:0] o_bcd_q, o_bcd_d;
  logic                    o_overflow_q, o_overflow_d;
  logic                    o_invalid_q, o_invalid_d;

  logic [3:0]              digit;
  logic [W_B:0]            sum;
  logic                    conv_go, conv_start, conv_ready, conv_done;
  logic [W_B-1:0]          conv_bin;
  logic [4*OUT_DIGITS-1:0] conv_bcd;

  // The input digits leave the MS end of nib_q, which shifts left one digit
  // per CONV_IN cycle.
  assign digit = nib_q[4*IN_DIGITS-1 -: 4];
  // The sum is one bit wider than the terms, so the saturation compare sees
  // the true value.
  assign sum   = {1'b0, t0_q} + {1'b0, t1_q};

  // NOTE: every *_d gets its default before the case, so no path can leave
  // a variable unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    nib_d        = nib_q;
    in_cnt_d     = in_cnt_q;
    n_d          = n_q;
    t0_d         = t0_q;
    t1_d         = t1_q;
    invalid_d    = invalid_q;
    overflow_d   = overflow_q;
    o_bcd_d      = o_bcd_q;
    o_overflow_d = o_overflow_q;
    o_invalid_d  = o_invalid_q;
    conv_go      = 1'b0;
    conv_bin     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          mode_d     = i_mode;
          nib_d      = i_bcd_n;
          in_cnt_d   = '0;
          n_d        = '0;
          invalid_d  = 1'b0;
          overflow_d = 1'b0;
          state_d    = S_CONV_IN;
        end
      end
      S_CONV_IN: begin
        nib_d    = nib_q << 4;
        in_cnt_d = in_cnt_q + W_IC'(1);
        // A bad digit leaves n alone. n is not used after a bad digit, and
        // this keeps it inside its range.
        if (digit > 4'd9) invalid_d = 1'b1;
        else              n_d = n_q * W_N'(10) + W_N'(digit);
        if (in_cnt_q == W_IC'(IN_DIGITS - 1)) begin
          if (invalid_d) begin
            conv_go  = 1'b1;
            conv_bin = MAX_RES;
            state_d  = S_CONV_OUT;
          end else begin
            t0_d    = (mode_q == MODE_LUCAS) ? W_B'(LUC_SEED0) : W_B'(FIB_SEED0);
            t1_d    = (mode_q == MODE_LUCAS) ? W_B'(LUC_SEED1) : W_B'(FIB_SEED1);
            state_d = S_OP;
          end
        end
      end
      S_OP: begin
        if (n_q == '0) begin
          conv_go  = 1'b1;
          conv_bin = t0_q;
          state_d  = S_CONV_OUT;
        end else if (n_q == W_N'(1)) begin
          conv_go  = 1'b1;
          conv_bin = t1_q;
          state_d  = S_CONV_OUT;
        end else if (sum > {1'b0, MAX_RES}) begin
          conv_go    = 1'b1;
          conv_bin   = MAX_RES;
          overflow_d = 1'b1;
          state_d    = S_CONV_OUT;
        end else begin
          t0_d = t1_q;
          t1_d = sum[W_B-1:0];
          n_d  = n_q - W_N'(1);
        end
      end
      S_CONV_OUT: begin
        if (conv_done) begin
          o_bcd_d      = conv_bcd;
          o_overflow_d = overflow_q;
          o_invalid_d  = invalid_q;
          state_d      = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // The handshake outputs are registered, so they are decoded from the
    // next state.
    o_ready_d     = (state_d == S_IDLE);
    o_done_tick_d = (state_d == S_DONE);
  end

  assign conv_start = conv_go & conv_ready;

  // NOTE: sequential state is written only with non-blocking assignments.
  // Every flop then samples its pre-edge value, whatever order the
  // statements are in.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q       <= S_IDLE;
      mode_q        <= MODE_FIB;
      nib_q         <= '0;
      in_cnt_q      <= '0;
      n_q           <= '0;
      t0_q          <= '0;
      t1_q          <= '0;
      invalid_q     <= 1'b0;
      overflow_q    <= 1'b0;
      o_ready_q     <= 1'b1;
      o_done_tick_q <= 1'b0;
      o_bcd_q       <= '0;
      o_overflow_q  <= 1'b0;
      o_invalid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      nib_q         <= nib_d;
      in_cnt_q      <= in_cnt_d;
      n_q           <= n_d;
      t0_q          <= t0_d;
      t1_q          <= t1_d;
      invalid_q     <= invalid_d;
      overflow_q    <= overflow_d;
      o_ready_q     <= o_ready_d;
      o_done_tick_q <= o_done_tick_d;
      o_bcd_q       <= o_bcd_d;
      o_overflow_q  <= o_overflow_d;
      o_invalid_q   <= o_invalid_d;
    end
  end

  bin_to_bcd_seq #(
    .W_B        (W_B),
    .OUT_DIGITS (OUT_DIGITS)
  ) u_bin_to_bcd (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_start     (conv_start),
    .i_bin       (conv_bin),
    .o_ready     (conv_ready),
    .o_done_tick (conv_done),
    .o_bcd       (conv_bcd)
  );

  assign o_ready     = o_ready_q;
  assign o_done_tick = o_done_tick_q;
  assign o_bcd       = o_bcd_q;
  assign o_overflow  = o_overflow_q;
  assign o_invalid   = o_invalid_q;

endmodule

// File: tb/tb_fib_seq_bcd.sv
// Bench for fib_seq_bcd. It drives a default 2/4-digit instance and a
// 6-digit-output instance. The expected results come from a sequence model
// that uses plain integer arithmetic, and the latency is checked on valid,
// non-saturating runs.
module tb_fib_seq_bcd;

  logic        clk;
  logic        rst;
  logic        start4, start6;
  logic        mode;
  logic [7:0]  bcd_n;
  logic        ready4, done4, ovf4, inv4;
  logic [15:0] bcd4;
  logic        ready6, done6, ovf6, inv6;
  logic [23:0] bcd6;

  int n_tests = 0;
  int n_fail  = 0;

  fib_seq_bcd #(.IN_DIGITS(2), .OUT_DIGITS(4)) dut4 (
    .i_clk (clk), .i_reset (rst), .i_start (start4), .i_mode (mode),
    .i_bcd_n (bcd_n), .o_ready (ready4), .o_done_tick (done4),
    .o_bcd (bcd4), .o_overflow (ovf4), .o_invalid (inv4)
  );

  fib_seq_bcd #(.IN_DIGITS(2), .OUT_DIGITS(6)) dut6 (
    .i_clk (clk), .i_reset (rst), .i_start (start6), .i_mode (mode),
    .i_bcd_n (bcd_n), .o_ready (ready6), .o_done_tick (done6),
    .o_bcd (bcd6), .o_overflow (ovf6), .o_invalid (inv6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // The model builds the sequence term by term. It stops at the first term
  // that does not fit in the output digits, then renders the value in BCD
  // by repeated division by 10.
  task automatic model(input logic m, input logic [7:0] nb, input int digits,
                       output logic [23:0] bcd, output logic ovf,
                       output logic inv, output int n_val);
    longint maxv;
    longint v;
    longint s[$];
    maxv = 1;
    for (int i = 0; i < digits; i++) maxv = maxv * 10;
    maxv = maxv - 1;
    inv   = (nb[7:4] > 4'd9) || (nb[3:0] > 4'd9);
    n_val = int'(nb[7:4]) * 10 + int'(nb[3:0]);
    ovf   = 1'b0;
    if (inv) begin
      v = maxv;
    end else begin
      s.push_back(m ? 2 : 0);
      s.push_back(1);
      for (int k = 2; k <= n_val; k++) begin
        if (s[k-1] + s[k-2] > maxv) begin
          ovf = 1'b1;
          break;
        end
        s.push_back(s[k-1] + s[k-2]);
      end
      v = ovf ? maxv : s[n_val];
    end
    bcd = '0;
    for (int d = 0; d < digits; d++) begin
      bcd[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
  endtask

  // Starts one operation in the next idle cycle and waits for done. It then
  // checks the result and, where the latency is defined, the latency.
  // glitch_at > 0 re-pulses start4 in that cycle of the operation.
  task automatic run_one(input int sel, input logic m, input logic [7:0] nb,
                         input int glitch_at, input string tag);
    logic [23:0] exp_bcd, got_bcd;
    logic        exp_ovf, exp_inv;
    int          n_val, lat, digits, w_b, exp_lat;
    bit          seen;
    digits = sel ? 6 : 4;
    w_b    = sel ? $clog2(1000000) : $clog2(10000);
    model(m, nb, digits, exp_bcd, exp_ovf, exp_inv, n_val);
    @(negedge clk);
    mode  = m;
    bcd_n = nb;
    if (sel != 0) start6 = 1'b1; else start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    start6 = 1'b0;
    lat    = 1;
    seen   = 1'b0;
    check({tag, "/busy"}, 64'(sel ? ready6 : ready4), 64'(0));
    while (!seen && lat < 400) begin
      if ((sel ? done6 : done4) === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (glitch_at > 0) start4 = (lat == glitch_at);
        @(negedge clk);
        lat++;
      end
    end
    start4 = 1'b0;
    if (!seen) begin
      check({tag, "/timeout"}, 64'(0), 64'(1));
    end else begin
      got_bcd = sel ? bcd6 : {8'h00, bcd4};
      check({tag, "/bcd"}, 64'(got_bcd), 64'(exp_bcd));
      check({tag, "/ovf"}, 64'(sel ? ovf6 : ovf4), 64'(exp_ovf));
      check({tag, "/inv"}, 64'(sel ? inv6 : inv4), 64'(exp_inv));
      if (!exp_ovf && !exp_inv) begin
        exp_lat = 2 + ((n_val > 1) ? n_val : 1) + w_b + 1;
        check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
      end
    end
  endtask

  initial begin
    logic [7:0] nb;
    bit         saw_done;
    rst    = 1'b1;
    start4 = 1'b0;
    start6 = 1'b0;
    mode   = 1'b0;
    bcd_n  = 8'h00;
    repeat (3) @(negedge clk);

    check("reset/ready", 64'(ready4), 64'(1));
    check("reset/done",  64'(done4),  64'(0));
    check("reset/bcd",   64'(bcd4),   64'(0));
    check("reset/ovf",   64'(ovf4),   64'(0));
    check("reset/inv",   64'(inv4),   64'(0));
    rst = 1'b0;

    // Directed cases, run back to back.
    run_one(0, 1'b0, 8'h10, 0, "fib10");
    check("fib10/literal", 64'(bcd4), 64'h0055);
    @(negedge clk);
    check("after_done/tick", 64'(done4),  64'(0));
    check("after_done/ready", 64'(ready4), 64'(1));
    run_one(0, 1'b0, 8'h00, 0, "fib0");
    run_one(0, 1'b1, 8'h00, 0, "lucas0");
    run_one(0, 1'b1, 8'h01, 0, "lucas1");
    run_one(0, 1'b0, 8'h01, 0, "fib1");
    run_one(0, 1'b0, 8'h20, 0, "fib20");
    run_one(0, 1'b0, 8'h21, 0, "fib21_sat");
    run_one(0, 1'b0, 8'h1A, 0, "bad_digit");
    run_one(0, 1'b0, 8'h05, 0, "fib5_after_bad");
    run_one(0, 1'b0, 8'h15, 8, "fib15_restart_ignored");
    run_one(0, 1'b1, 8'h20, 0, "lucas20_sat");

    // A reset in the middle of OP aborts the run and restores reset values.
    @(negedge clk);
    mode   = 1'b0;
    bcd_n  = 8'h20;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort/ready", 64'(ready4), 64'(1));
    check("abort/bcd",   64'(bcd4),   64'(0));
    check("abort/ovf",   64'(ovf4),   64'(0));
    check("abort/done",  64'(done4),  64'(0));
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done4 === 1'b1) saw_done = 1'b1;
    end
    check("abort/no_done", 64'(saw_done), 64'(0));

    // Six-digit output instance.
    run_one(1, 1'b0, 8'h30, 0, "w6_fib30");
    check("w6_fib30/literal", 64'(bcd6), 64'h832040);
    run_one(1, 1'b0, 8'h31, 0, "w6_fib31_sat");

    // Random operands, with an occasional bad digit.
    for (int i = 0; i < 24; i++) begin
      nb = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 1) nb[7:4] = 4'($urandom_range(10, 15));
        else                           nb[3:0] = 4'($urandom_range(10, 15));
      end
      run_one((i % 4 == 3) ? 1 : 0, 1'($urandom_range(0, 1)), nb, 0,
              $sformatf("rand%0d_n%02h", i, nb));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
